param_serial_tx: RTL and testbench
==================================

PARAM_SERIAL_TX -- requirements
Module: param_serial_tx

Interface
REQ-001: Parameter DATA_W, default 32, is the width of the input word.
REQ-002: Parameter OUT_W, default 4, is the width of each output chunk; DATA_W % OUT_W SHALL be 0, checked at elaboration.
REQ-003: Parameter DEPTH, default 4, is the number of input FIFO entries; it SHALL be at least 1.
REQ-004: Parameter DIV_W, default 8, is the width of the clock-divider register.
REQ-005: Clk  in  1  is the single clock; all logic is on its rising edge.
REQ-006: Reset  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-007: ValidCmd  in  1  is the push request for Din.
REQ-008: ConfigDiv  in  1  is the divider load request; it loads Din[DIV_W-1:0].
REQ-009: Din  in  DATA_W  is the data word or divider value.
REQ-010: Busy  out  1  is asserted when the FIFO is full (count == DEPTH), derived from the count register.
REQ-011: FifoLevel  out  $clog2(DEPTH+1)  is the current FIFO occupancy.
REQ-012: ClkTx  out  1  is the divided transmit clock, registered.
REQ-013: DOutValid  out  1  is high while DataOut carries a valid chunk.
REQ-014: DataOut  out  OUT_W  is the current chunk, registered.

Function
REQ-015: Constant CHUNKS = DATA_W/OUT_W.
REQ-016: Push rule: ValidCmd=1, Busy=0 and ConfigDiv=0 SHALL write Din into the FIFO; ValidCmd while Busy=1 is dropped silently, with no state change.
REQ-017: Priority: ConfigDiv=1 together with ValidCmd=1 in the same cycle SHALL never push.
REQ-018: ConfigDiv is honoured only in state IDLE with the FIFO empty: DivReg <= Din[DIV_W-1:0]; otherwise it is ignored.
REQ-019: State machine states are IDLE, LOAD and SHIFT.
REQ-020: IDLE: ClkTx=0, DOutValid=0, DataOut holds 0, divider counter=0; a non-empty FIFO moves the FSM to LOAD.
REQ-021: LOAD (one cycle): pop the FIFO head into the shift register, chunk index <= 0, divider counter <= 0, then go to SHIFT.
REQ-022: SHIFT drives chunk k = shift[DATA_W-1-k*OUT_W -: OUT_W], MSB chunk first, with DOutValid=1.
REQ-023: In SHIFT the divider counter counts 0..DivReg; at terminal count ClkTx toggles and the counter wraps to 0.
REQ-024: ClkTx SHALL be 0 when a chunk is first presented; each chunk is held for exactly 2*(DivReg+1) Clk cycles (one full ClkTx period, low then high).
REQ-025: The chunk advances on the cycle where ClkTx toggles 1->0.
REQ-026: DivReg=0 gives a ClkTx toggle every cycle and one chunk per 2 cycles.
REQ-027: After the last chunk's period, a non-empty FIFO SHALL pop the next word in that same cycle, so the next word's chunk 0 follows with no idle cycle; DOutValid stays 1.
REQ-028: After the last chunk's period with the FIFO empty, the FSM returns to IDLE and DOutValid=0 on the next cycle.
REQ-029: Latency: a push into an empty FIFO with the FSM in IDLE at edge t SHALL present chunk 0 with DOutValid=1 after edge t+2.
REQ-030: A simultaneous pop and push when not full SHALL leave FifoLevel unchanged.
REQ-031: When full, a pop in the same cycle does not admit the push, because Busy is registered-count based.
REQ-032: FIFO read and write pointers SHALL wrap modulo DEPTH, including for non-power-of-2 DEPTH.
REQ-033: DivReg is not changeable mid-word (ignored per REQ-018), so chunk timing within a word is constant.

Reset
REQ-034: Reset=1 at a clock edge SHALL set state=IDLE, FIFO count and pointers to 0, DivReg=0, divider counter=0, chunk index=0, and the shift register to 0.
REQ-035: Reset output values SHALL be ClkTx=0, DOutValid=0, DataOut=0, Busy=0 and FifoLevel=0.
REQ-036: Reset mid-word SHALL discard the partial word and all queued words; the next cycle after Reset deasserts behaves as power-up.
REQ-037: Reset has priority over ValidCmd and ConfigDiv.

Structure
REQ-038: Package tx_pkg SHALL hold the tx_state_t enum (IDLE, LOAD, SHIFT) and the default parameter constants.
REQ-039: Sub-module tx_fifo (parameters DATA_W and DEPTH; push, pop, data, count, full, empty) SHALL be instantiated once; the FSM, divider and shifter stay in param_serial_tx.

Verification
REQ-040: Defaults, DivReg=0, push 0x1234_ABCD -> DataOut sequence 1,2,3,4,A,B,C,D, each chunk 2 cycles, first at t+2, then DOutValid=0.
REQ-041: ConfigDiv with Din=3 in IDLE, then push 0xF000_000F -> each chunk held 8 cycles, ClkTx period 8, total 64 cycles valid.
REQ-042: 5 back-to-back pushes at DEPTH=4 while transmitting -> Busy=1 once full, the 5th word is dropped, and exactly 4 or 5 words are emitted per FIFO timing with no inter-word gap.
REQ-043: ConfigDiv=1 during SHIFT with Din=7 -> DivReg is unchanged; ValidCmd+ConfigDiv together in IDLE -> DivReg loaded and FifoLevel stays 0.
REQ-044: Reset asserted mid-chunk 3 -> next cycle all outputs are 0, FifoLevel=0, and a subsequent push restarts at chunk 0.
REQ-045: DATA_W=16, OUT_W=8, DEPTH=3, push 0xA55A three times -> AA? no: A5,5A repeated three times, with pointer wrap exercised and no data loss.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and default parameter values for the chunked serial transmitter.
package tx_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_OUT_W  = 4;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_DIV_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Word FIFO with modulo-DEPTH pointers; works for any DEPTH >= 1.
module tx_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doPush;
  logic              doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (!doPush && doPop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/param_serial_tx.sv
// Serialises queued words MSB-chunk first, one chunk per full period of the divided ClkTx.
module param_serial_tx
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DIV_W  = DEF_DIV_W,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ValidCmd,
  input  logic              ConfigDiv,
  input  logic [DATA_W-1:0] Din,
  output logic              Busy,
  output logic [LVL_W-1:0]  FifoLevel,
  output logic              ClkTx,
  output logic              DOutValid,
  output logic [OUT_W-1:0]  DataOut
);

  localparam int unsigned CHUNKS = DATA_W / OUT_W;
  localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if (DATA_W % OUT_W != 0) begin : gBadOutW
    $error("DATA_W must be a multiple of OUT_W");
  end
  if (DEPTH < 1) begin : gBadDepth
    $error("DEPTH must be at least 1");
  end

  tx_state_t         state;
  logic [DIV_W-1:0]  divReg;
  logic [DIV_W-1:0]  divCnt;
  logic [IDX_W-1:0]  chunkIdx;
  logic [DATA_W-1:0] shiftReg;
  logic [DATA_W-1:0] fifoHead;
  logic [LVL_W-1:0]  fifoCount;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic              termCnt;
  logic              lastChunk;
  logic              wordDone;

  // Chunk k of a word, counted from the MSB end.
  function automatic logic [OUT_W-1:0] chunkOf(input logic [DATA_W-1:0] w,
                                               input logic [IDX_W-1:0]  k);
    return OUT_W'(w >> (OUT_W * (CHUNKS - 1 - 32'(k))));
  endfunction

  assign fifoPush  = ValidCmd && !ConfigDiv && !fifoFull;
  assign termCnt   = (divCnt == divReg);
  assign lastChunk = (chunkIdx == IDX_W'(CHUNKS - 1));
  assign wordDone  = (state == SHIFT) && termCnt && ClkTx && lastChunk;
  assign fifoPop   = (state == LOAD) || (wordDone && !fifoEmpty);
  assign Busy      = fifoFull;
  assign FifoLevel = fifoCount;

  tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk    (Clk),
    .reset  (Reset),
    .push   (fifoPush),
    .pop    (fifoPop),
    .wrData (Din),
    .rdData (fifoHead),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      divReg    <= '0;
      divCnt    <= '0;
      chunkIdx  <= '0;
      shiftReg  <= '0;
      ClkTx     <= 1'b0;
      DOutValid <= 1'b0;
      DataOut   <= '0;
    end else begin
      // Divider only reloads between words so a word never changes speed mid-flight.
      if (ConfigDiv && (state == IDLE) && fifoEmpty) divReg <= Din[DIV_W-1:0];

      case (state)
        IDLE: begin
          ClkTx     <= 1'b0;
          DOutValid <= 1'b0;
          DataOut   <= '0;
          divCnt    <= '0;
          if (!fifoEmpty) state <= LOAD;
        end
        LOAD: begin
          shiftReg  <= fifoHead;
          chunkIdx  <= '0;
          divCnt    <= '0;
          ClkTx     <= 1'b0;
          DOutValid <= 1'b1;
          DataOut   <= chunkOf(fifoHead, '0);
          state     <= SHIFT;
        end
        SHIFT: begin
          if (!termCnt) begin
            divCnt <= divCnt + 1'b1;
          end else begin
            divCnt <= '0;
            ClkTx  <= ~ClkTx;
            // Falling ClkTx closes a chunk period.
            if (ClkTx) begin
              if (!lastChunk) begin
                chunkIdx <= chunkIdx + 1'b1;
                DataOut  <= chunkOf(shiftReg, chunkIdx + 1'b1);
              end else if (!fifoEmpty) begin
                shiftReg <= fifoHead;
                chunkIdx <= '0;
                DataOut  <= chunkOf(fifoHead, '0);
              end else begin
                chunkIdx  <= '0;
                DOutValid <= 1'b0;
                DataOut   <= '0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_serial_tx.sv
// Bench: scoreboarded chunk stream checks for a default instance and a 16/8/3 instance.
module tb_param_serial_tx;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        ResetA, ValidCmdA, ConfigDivA;
  logic [31:0] DinA;
  logic        BusyA, ClkTxA, DOutValidA;
  logic [2:0]  FifoLevelA;
  logic [3:0]  DataOutA;

  logic        ResetB, ValidCmdB, ConfigDivB;
  logic [15:0] DinB;
  logic        BusyB, ClkTxB, DOutValidB;
  logic [1:0]  FifoLevelB;
  logic [7:0]  DataOutB;

  param_serial_tx dutA (
    .Clk(Clk), .Reset(ResetA), .ValidCmd(ValidCmdA), .ConfigDiv(ConfigDivA), .Din(DinA),
    .Busy(BusyA), .FifoLevel(FifoLevelA), .ClkTx(ClkTxA), .DOutValid(DOutValidA), .DataOut(DataOutA)
  );

  param_serial_tx #(.DATA_W(16), .OUT_W(8), .DEPTH(3), .DIV_W(8)) dutB (
    .Clk(Clk), .Reset(ResetB), .ValidCmd(ValidCmdB), .ConfigDiv(ConfigDivB), .Din(DinB),
    .Busy(BusyB), .FifoLevel(FifoLevelB), .ClkTx(ClkTxB), .DOutValid(DOutValidB), .DataOut(DataOutB)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] qA[$];
  logic [7:0] qB[$];

  int periodA = 2;
  int holdA = 0, runA = 0, lastRunA = 0, fallCntA = 0;
  bit prevA = 1'b0, ignoreA = 1'b0;
  int holdB = 0, runB = 0, lastRunB = 0, fallCntB = 0;
  bit prevB = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  div;
    int          expRun;
    logic [3:0]  expFirst;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor A: new chunk on valid rise or after a full period; ClkTx low then high.
  always @(negedge Clk) begin
    if (DOutValidA) begin
      if (!prevA || holdA == periodA) begin
        if (qA.size() == 0) check("chunkA_unexpected", {60'd0, DataOutA}, 64'hFFFF);
        else check("chunkA", {60'd0, DataOutA}, {60'd0, qA.pop_front()});
        check("clkTxStartA", ClkTxA, 0);
        holdA = 1;
      end else begin
        holdA++;
        check("clkTxA", ClkTxA, (holdA > periodA / 2) ? 1 : 0);
      end
      runA++;
    end else begin
      if (prevA) begin
        if (!ignoreA) check("lastHoldA", holdA, periodA);
        ignoreA  = 1'b0;
        lastRunA = runA;
        runA     = 0;
        holdA    = 0;
        fallCntA++;
      end
      check("idleOutA", {ClkTxA, DataOutA}, 0);
    end
    prevA = DOutValidA;
  end

  // Monitor B: divider stays 0 so each chunk lasts 2 cycles.
  always @(negedge Clk) begin
    if (DOutValidB) begin
      if (!prevB || holdB == 2) begin
        if (qB.size() == 0) check("chunkB_unexpected", {56'd0, DataOutB}, 64'hFFFF);
        else check("chunkB", {56'd0, DataOutB}, {56'd0, qB.pop_front()});
        check("clkTxStartB", ClkTxB, 0);
        holdB = 1;
      end else begin
        holdB++;
        check("clkTxB", ClkTxB, 1);
      end
      runB++;
    end else if (prevB) begin
      check("lastHoldB", holdB, 2);
      lastRunB = runB;
      runB     = 0;
      holdB    = 0;
      fallCntB++;
    end
    prevB = DOutValidB;
  end

  task automatic pushA(input logic [31:0] w, input bit accept);
    ValidCmdA = 1'b1;
    DinA      = w;
    if (accept) for (int k = 0; k < 8; k++) qA.push_back(4'(w >> (28 - 4 * k)));
    step();
    ValidCmdA = 1'b0;
  endtask

  task automatic pushB(input logic [15:0] w);
    ValidCmdB = 1'b1;
    DinB      = w;
    for (int k = 0; k < 2; k++) qB.push_back(8'(w >> (8 - 8 * k)));
    step();
    ValidCmdB = 1'b0;
  endtask

  task automatic configA(input logic [7:0] d);
    ConfigDivA = 1'b1;
    DinA       = {24'd0, d};
    step();
    ConfigDivA = 1'b0;
    periodA    = 2 * (int'(d) + 1);
  endtask

  task automatic waitFallA(input int budget, input string name);
    int f0 = fallCntA;
    int n  = 0;
    while (fallCntA == f0 && n < budget) begin step(); n++; end
    if (fallCntA == f0) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic waitValidA(input int budget);
    int n = 0;
    while (!DOutValidA && n < budget) begin step(); n++; end
    if (!DOutValidA) check("waitValidA_timeout", 0, 1);
  endtask

  task automatic checkResetA(input string name);
    check({name, "_ClkTx"}, ClkTxA, 0);
    check({name, "_DOutValid"}, DOutValidA, 0);
    check({name, "_DataOut"}, DataOutA, 0);
    check({name, "_Busy"}, BusyA, 0);
    check({name, "_FifoLevel"}, FifoLevelA, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h1234ABCD, 8'd0, 16, 4'h1};
    vecs[1] = '{32'hF000000F, 8'd3, 64, 4'hF};
    vecs[2] = '{32'h00000000, 8'd1, 32, 4'h0};
    vecs[3] = '{32'h89ABCDEF, 8'd2, 48, 4'h8};
    vecs[4] = '{32'h5A5A5A5A, 8'd0, 16, 4'h5};

    ResetA = 1'b1; ValidCmdA = 1'b0; ConfigDivA = 1'b0; DinA = '0;
    ResetB = 1'b1; ValidCmdB = 1'b0; ConfigDivB = 1'b0; DinB = '0;
    repeat (2) step();
    checkResetA("resetA");
    check("resetB_Busy", BusyB, 0);
    check("resetB_FifoLevel", FifoLevelB, 0);
    check("resetB_DOutValid", DOutValidB, 0);
    ResetA = 1'b0;
    ResetB = 1'b0;
    step();

    // Single words at several divider settings, with two-edge latency.
    for (int i = 0; i < 5; i++) begin
      configA(vecs[i].div);
      pushA(vecs[i].word, 1'b1);
      step();
      check($sformatf("vec%0d_latT1", i), DOutValidA, 0);
      step();
      check($sformatf("vec%0d_latT2", i), DOutValidA, 1);
      check($sformatf("vec%0d_first", i), DataOutA, vecs[i].expFirst);
      waitFallA(400, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_run", i), lastRunA, vecs[i].expRun);
    end

    // Fill while transmitting: fifth word is dropped, four queued words follow gaplessly.
    configA(8'd3);
    pushA(32'hCAFE0001, 1'b1);
    waitValidA(20);
    pushA(32'h11112222, 1'b1);
    pushA(32'h33334444, 1'b1);
    pushA(32'h55556666, 1'b1);
    pushA(32'h77778888, 1'b1);
    check("full_Busy", BusyA, 1);
    check("full_Level", FifoLevelA, 4);
    pushA(32'hDEAD0005, 1'b0);
    check("drop_Busy", BusyA, 1);
    check("drop_Level", FifoLevelA, 4);
    waitFallA(800, "b2b");
    check("b2b_run", lastRunA, 320);
    check("b2b_queue", qA.size(), 0);

    // ConfigDiv mid-word is ignored; the divider stays 3 for this and the next word.
    pushA(32'h0BADF00D, 1'b1);
    waitValidA(20);
    ConfigDivA = 1'b1;
    DinA       = 32'd7;
    step();
    ConfigDivA = 1'b0;
    waitFallA(200, "cfgShift");
    check("cfgShift_run", lastRunA, 64);
    pushA(32'h13579BDF, 1'b1);
    waitFallA(200, "cfgKeep");
    check("cfgKeep_run", lastRunA, 64);

    // ValidCmd with ConfigDiv in IDLE: divider loads, nothing is queued.
    ValidCmdA  = 1'b1;
    ConfigDivA = 1'b1;
    DinA       = 32'd1;
    step();
    ValidCmdA  = 1'b0;
    ConfigDivA = 1'b0;
    periodA    = 4;
    check("cfgIdle_Level", FifoLevelA, 0);
    step();
    step();
    check("cfgIdle_noValid", DOutValidA, 0);
    pushA(32'h2468ACE0, 1'b1);
    waitFallA(200, "cfgIdle");
    check("cfgIdle_run", lastRunA, 32);

    // Reset during chunk 3 with a second word still queued.
    configA(8'd0);
    pushA(32'h76543210, 1'b1);
    pushA(32'h0F0F0F0F, 1'b1);
    begin
      int n = 0;
      while (runA != 7 && n < 40) begin step(); n++; end
      check("midReset_reach", runA, 7);
    end
    check("midReset_chunk3", DataOutA, 4'h4);
    ResetA  = 1'b1;
    ignoreA = 1'b1;
    step();
    qA.delete();
    periodA = 2;
    checkResetA("midReset");
    ResetA = 1'b0;
    step();
    pushA(32'h9ABCDEF0, 1'b1);
    waitFallA(100, "postReset");
    check("postReset_run", lastRunA, 16);
    check("postReset_queue", qA.size(), 0);

    // Narrow instance: DEPTH=3, pointers wrap, fills exactly, no data lost.
    pushB(16'hA55A);
    pushB(16'hA55A);
    pushB(16'hA55A);
    pushB(16'hC33C);
    check("B_full_Busy", BusyB, 1);
    check("B_full_Level", FifoLevelB, 3);
    begin
      int f0 = fallCntB;
      int n  = 0;
      while (fallCntB == f0 && n < 100) begin step(); n++; end
      if (fallCntB == f0) check("B_timeout", 0, 1);
    end
    check("B_run", lastRunB, 16);
    check("B_queue", qB.size(), 0);
    check("B_Level_end", FifoLevelB, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
